// File: rtl/det_engine_n.sv
// det_engine_n: NxN signed determinant by fraction-free (Bareiss) elimination, one element update per cycle.
// Define DET_PIVOT_EN to compile in row pivoting; without it a zero pivot ends the job with Zero_pivot.
module det_engine_n #(
  parameter int N  = 4,
  parameter int W  = 16,
  parameter int DW = 64
) (
  input  logic                 Clk,
  input  logic                 Reset_n,
  input  logic                 Start,
  input  logic                 In_valid,
  input  logic signed [W-1:0]  In_data,
  input  logic                 Ack,
  output logic                 In_ready,
  output logic signed [DW-1:0] Det,
  output logic                 Singular,
  output logic                 Zero_pivot,
  output logic                 q_I,
  output logic                 q_Load,
  output logic                 q_Pivot,
  output logic                 q_Comp,
  output logic                 q_Done
);
  localparam int PW = 2 * DW;
  localparam int IW = (N > 2) ? $clog2(N) : 1;
  localparam logic [IW-1:0] ONE    = IW'(1);
  localparam logic [IW-1:0] LAST   = IW'(N - 1);
  localparam logic [IW-1:0] PENULT = IW'(N - 2);

  typedef enum logic [2:0] {S_I, S_LOAD, S_PIVOT, S_COMP, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [IW-1:0]        k_q, k_d, i_q, i_d, j_q, j_d;
  logic signed [DW-1:0] prev_q, prev_d, det_q, det_d;
  logic                 neg_q, neg_d, sing_q, sing_d, zp_q, zp_d;
  logic signed [DW-1:0] a_q [N][N];
  logic signed [DW-1:0] a_d [N][N];
  logic signed [PW-1:0] num;
  logic signed [DW-1:0] upd;
`ifdef DET_PIVOT_EN
  logic [IW-1:0]        p_q, p_d;
  logic                 scan_q, scan_d;
`endif

  // Products are kept at double width; only the exact quotient must fit in DW.
  always_comb begin
    num = PW'(a_q[i_q][j_q]) * PW'(a_q[k_q][k_q]) - PW'(a_q[i_q][k_q]) * PW'(a_q[k_q][j_q]);
    upd = DW'(num / PW'(prev_q));
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    j_d     = j_q;
    prev_d  = prev_q;
    neg_d   = neg_q;
    det_d   = det_q;
    sing_d  = sing_q;
    zp_d    = zp_q;
    a_d     = a_q;
`ifdef DET_PIVOT_EN
    p_d     = p_q;
    scan_d  = scan_q;
`endif
    case (state_q)
      S_I: begin
        if (Start) begin
          state_d = S_LOAD;
          i_d     = '0;
          j_d     = '0;
          sing_d  = 1'b0;
          zp_d    = 1'b0;
        end
      end
      S_LOAD: begin
        if (In_valid) begin
          a_d[i_q][j_q] = DW'(In_data);
          if (j_q == LAST) begin
            j_d = '0;
            if (i_q == LAST) begin
              state_d = S_PIVOT;
              k_d     = '0;
              prev_d  = DW'(1);
              neg_d   = 1'b0;
`ifdef DET_PIVOT_EN
              scan_d  = 1'b0;
`endif
            end else begin
              i_d = i_q + ONE;
            end
          end else begin
            j_d = j_q + ONE;
          end
        end
      end
      S_PIVOT: begin
`ifdef DET_PIVOT_EN
        if (!scan_q) begin
          if (a_q[k_q][k_q] != '0) begin
            state_d = S_COMP;
            i_d     = k_q + ONE;
            j_d     = k_q + ONE;
          end else begin
            scan_d = 1'b1;
            p_d    = k_q + ONE;
          end
        end else if (a_q[p_q][k_q] != '0) begin
          for (int c = 0; c < N; c++) begin
            a_d[k_q][c] = a_q[p_q][c];
            a_d[p_q][c] = a_q[k_q][c];
          end
          neg_d   = ~neg_q;
          scan_d  = 1'b0;
          state_d = S_COMP;
          i_d     = k_q + ONE;
          j_d     = k_q + ONE;
        end else if (p_q == LAST) begin
          scan_d  = 1'b0;
          det_d   = '0;
          sing_d  = 1'b1;
          state_d = S_DONE;
        end else begin
          p_d = p_q + ONE;
        end
`else
        if (a_q[k_q][k_q] != '0) begin
          state_d = S_COMP;
          i_d     = k_q + ONE;
          j_d     = k_q + ONE;
        end else begin
          det_d   = '0;
          zp_d    = 1'b1;
          state_d = S_DONE;
        end
`endif
      end
      S_COMP: begin
        a_d[i_q][j_q] = upd;
        if (j_q == LAST) begin
          if (i_q == LAST) begin
            prev_d = a_q[k_q][k_q];
            k_d    = k_q + ONE;
            if (k_q == PENULT) begin
              state_d = S_DONE;
              det_d   = neg_q ? -upd : upd;
            end else begin
              state_d = S_PIVOT;
            end
          end else begin
            i_d = i_q + ONE;
            j_d = k_q + ONE;
          end
        end else begin
          j_d = j_q + ONE;
        end
      end
      S_DONE: begin
        if (Ack) state_d = S_I;
      end
      default: state_d = S_I;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_I;
      k_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      prev_q  <= DW'(1);
      det_q   <= '0;
      neg_q   <= 1'b0;
      sing_q  <= 1'b0;
      zp_q    <= 1'b0;
`ifdef DET_PIVOT_EN
      p_q     <= '0;
      scan_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      j_q     <= j_d;
      prev_q  <= prev_d;
      det_q   <= det_d;
      neg_q   <= neg_d;
      sing_q  <= sing_d;
      zp_q    <= zp_d;
`ifdef DET_PIVOT_EN
      p_q     <= p_d;
      scan_q  <= scan_d;
`endif
    end
  end

  // Matrix contents need no reset; they are fully rewritten by every load.
  always_ff @(posedge Clk) a_q <= a_d;

  assign Det        = det_q;
  assign Singular   = sing_q;
  assign Zero_pivot = zp_q;
  assign In_ready   = (state_q == S_LOAD);
  assign q_I        = (state_q == S_I);
  assign q_Load     = (state_q == S_LOAD);
  assign q_Pivot    = (state_q == S_PIVOT);
  assign q_Comp     = (state_q == S_COMP);
  assign q_Done     = (state_q == S_DONE);

endmodule
